// File: rtl/sw_driver_pkg.sv
// Shared types and defaults for the switch-stimulus driver.
package sw_driver_pkg;

   localparam int unsigned DEPTH_DEF   = 16;
   localparam int unsigned TIMEOUT_DEF = 1024;

   typedef enum logic [1:0] {
      StIdle,
      StWaitAck,
      StDone,
      StTout
   } state_e;

   // Index width that stays legal for a single-entry table.
   function automatic int unsigned idx_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/sw_driver_if.sv
// Control/status and CPU-facing bus of sw_driver; slave is the driver, master its user.
interface sw_driver_if #(
   parameter int unsigned DEPTH = sw_driver_pkg::DEPTH_DEF
);
   localparam int unsigned IDX_W = sw_driver_pkg::idx_width(DEPTH);
   localparam int unsigned LEN_W = IDX_W + 1;

   logic             i_load_en;
   logic [IDX_W-1:0] i_load_addr;
   logic [31:0]      i_load_data;
   logic             i_start;
   logic [LEN_W-1:0] i_len;
   logic [31:0]      i_io_ledg;
   logic [31:0]      o_io_sw;
   logic             o_busy;
   logic             o_done;
   logic             o_timeout;
   logic [IDX_W-1:0] o_idx;

   modport master (
      output i_load_en, i_load_addr, i_load_data, i_start, i_len, i_io_ledg,
      input  o_io_sw, o_busy, o_done, o_timeout, o_idx
   );

   modport slave (
      input  i_load_en, i_load_addr, i_load_data, i_start, i_len, i_io_ledg,
      output o_io_sw, o_busy, o_done, o_timeout, o_idx
   );

endinterface

// File: rtl/sw_table.sv
// DEPTH x 32 stimulus register file: sync reset, one write port, async read port.
module sw_table
   import sw_driver_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   localparam int unsigned IDX_W = idx_width(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_waddr,
   input  logic [31:0]      i_wdata,
   input  logic [IDX_W-1:0] i_raddr,
   output logic [31:0]      o_rdata
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (i_we) begin
         mem_q[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/sw_driver.sv
// Presents table words to a CPU switch port with a toggling phase bit and waits
// for the CPU to echo that phase on ledg[0] before moving to the next word.
module sw_driver
   import sw_driver_pkg::*;
#(
   parameter int unsigned DEPTH   = DEPTH_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input logic         i_clk,
   input logic         i_reset,
   sw_driver_if.slave  bus
);

   localparam int unsigned IDX_W = idx_width(DEPTH);
   localparam int unsigned LEN_W = IDX_W + 1;
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_e           state_q, state_d;
   logic [31:0]      sw_q, sw_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             tbl_we;
   logic [IDX_W-1:0] rd_addr;
   logic [31:0]      rd_data;
   logic [LEN_W-1:0] len_clamped;
   logic             ack;
   logic             unused_bits;

   sw_table #(
      .DEPTH (DEPTH)
   ) u_table (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_we    (tbl_we),
      .i_waddr (bus.i_load_addr),
      .i_wdata (bus.i_load_data),
      .i_raddr (rd_addr),
      .o_rdata (rd_data)
   );

   assign len_clamped = (bus.i_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.i_len;
   assign ack         = (state_q == StWaitAck) && (bus.i_io_ledg[0] == sw_q[31]);
   // Outside WAIT_ACK the only word ever fetched is the first one.
   assign rd_addr     = (state_q == StWaitAck) ? idx_q + IDX_W'(1) : '0;
   assign unused_bits = ^{bus.i_io_ledg[31:1], rd_data[31]};

   always_comb begin
      state_d = state_q;
      sw_d    = sw_q;
      idx_d   = idx_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      tbl_we  = 1'b0;
      unique case (state_q)
         StIdle, StDone, StTout: begin
            if (bus.i_start) begin
               if (len_clamped == '0) begin
                  state_d = StDone;
               end else begin
                  state_d = StWaitAck;
                  len_d   = len_clamped;
                  idx_d   = '0;
                  cnt_d   = '0;
                  sw_d    = {~sw_q[31], rd_data[30:0]};
               end
            end else begin
               tbl_we = bus.i_load_en;
            end
         end
         StWaitAck: begin
            if (ack) begin
               if ({1'b0, idx_q} == len_q - LEN_W'(1)) begin
                  state_d = StDone;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  cnt_d = '0;
                  sw_d  = {~sw_q[31], rd_data[30:0]};
               end
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = StTout;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= StIdle;
         sw_q    <= '0;
         idx_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sw_q    <= sw_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.o_io_sw   = sw_q;
   assign bus.o_idx     = idx_q;
   assign bus.o_busy    = (state_q == StWaitAck);
   assign bus.o_done    = (state_q == StDone);
   assign bus.o_timeout = (state_q == StTout);

endmodule

// File: tb/tb_sw_driver.sv
// Self-checking bench for sw_driver: vector table plus hand-written corner sequences.
module tb_sw_driver;
   import sw_driver_pkg::*;

   localparam int unsigned DEPTH   = 16;
   localparam int unsigned TIMEOUT = 8;

   logic i_clk   = 1'b0;
   logic i_reset = 1'b1;

   sw_driver_if #(.DEPTH(DEPTH)) bus ();

   sw_driver #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] sw;
      logic [3:0]  idx;
      logic        busy;
      logic        done;
      logic        tout;
   } exp_t;

   typedef struct {
      logic        start;
      logic [4:0]  len;
      logic        load_en;
      logic [3:0]  load_addr;
      logic [31:0] load_data;
      logic        ledg0;
      exp_t        exp;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[8];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic exp_t mk(input logic [31:0] sw, input logic [3:0] idx,
                               input logic busy, input logic done, input logic tout);
      exp_t e;
      e.sw = sw; e.idx = idx; e.busy = busy; e.done = done; e.tout = tout;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic drive(input logic start, input logic [4:0] len, input logic load_en,
                        input logic [3:0] addr, input logic [31:0] data, input logic ledg0);
      bus.i_start     = start;
      bus.i_len       = len;
      bus.i_load_en   = load_en;
      bus.i_load_addr = addr;
      bus.i_load_data = data;
      bus.i_io_ledg   = {31'h0, ledg0};
   endtask

   task automatic step_idle(input logic ledg0);
      drive(1'b0, 5'd0, 1'b0, 4'd0, 32'h0, ledg0);
   endtask

   // One clock edge, then pop the expectation pushed for it and compare.
   task automatic step();
      exp_t e;
      @(posedge i_clk);
      #1;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL scoreboard @%0t: got empty queue expected an entry", $time);
      end else begin
         e = sb.pop_front();
         check("io_sw",   bus.o_io_sw,           e.sw);
         check("idx",     32'(bus.o_idx),        32'(e.idx));
         check("busy",    32'(bus.o_busy),       32'(e.busy));
         check("done",    32'(bus.o_done),       32'(e.done));
         check("timeout", 32'(bus.o_timeout),    32'(e.tout));
      end
   endtask

   task automatic expect_step(input exp_t e);
      sb.push_back(e);
      step();
   endtask

   initial begin
      logic ph;

      vecs[0] = '{1'b1, 5'd3, 1'b0, 4'd0, 32'h0,  1'b0, mk(32'h80000011, 4'd0, 1, 0, 0)};
      vecs[1] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,  1'b0, mk(32'h80000011, 4'd0, 1, 0, 0)};
      vecs[2] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,  1'b1, mk(32'h00000022, 4'd1, 1, 0, 0)};
      vecs[3] = '{1'b1, 5'd1, 1'b1, 4'd2, 32'h99, 1'b1, mk(32'h00000022, 4'd1, 1, 0, 0)};
      vecs[4] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,  1'b1, mk(32'h00000022, 4'd1, 1, 0, 0)};
      vecs[5] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,  1'b0, mk(32'h80000033, 4'd2, 1, 0, 0)};
      vecs[6] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,  1'b1, mk(32'h80000033, 4'd2, 0, 1, 0)};
      vecs[7] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,  1'b1, mk(32'h80000033, 4'd2, 0, 1, 0)};

      // Reset state
      step_idle(1'b0);
      expect_step(mk(32'h0, 4'd0, 0, 0, 0));
      i_reset = 1'b0;

      // Load table[0..2]
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 5'd0, 1'b1, 4'(i), 32'(8'h11 * (i + 1)), 1'b0);
         expect_step(mk(32'h0, 4'd0, 0, 0, 0));
      end

      // Three-word sequence, with a load and start pulsed while busy
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].start, vecs[i].len, vecs[i].load_en, vecs[i].load_addr,
               vecs[i].load_data, vecs[i].ledg0);
         expect_step(vecs[i].exp);
      end

      // Start and load in the same cycle: start wins, load dropped
      drive(1'b1, 5'd1, 1'b1, 4'd0, 32'h55, 1'b1);
      expect_step(mk(32'h00000011, 4'd0, 1, 0, 0));
      step_idle(1'b0);
      expect_step(mk(32'h00000011, 4'd0, 0, 1, 0));
      drive(1'b1, 5'd1, 1'b0, 4'd0, 32'h0, 1'b0);
      expect_step(mk(32'h80000011, 4'd0, 1, 0, 0));
      step_idle(1'b1);
      expect_step(mk(32'h80000011, 4'd0, 0, 1, 0));

      // Timeout: 8 cycles in WAIT_ACK without an ack
      drive(1'b1, 5'd2, 1'b0, 4'd0, 32'h0, 1'b1);
      expect_step(mk(32'h00000011, 4'd0, 1, 0, 0));
      for (int k = 1; k < 8; k++) begin
         step_idle(1'b1);
         expect_step(mk(32'h00000011, 4'd0, 1, 0, 0));
      end
      step_idle(1'b1);
      expect_step(mk(32'h00000011, 4'd0, 0, 0, 1));
      step_idle(1'b1);
      expect_step(mk(32'h00000011, 4'd0, 0, 0, 1));

      // len=0 goes straight to DONE, io_sw unchanged
      drive(1'b1, 5'd0, 1'b0, 4'd0, 32'h0, 1'b1);
      expect_step(mk(32'h00000011, 4'd0, 0, 1, 0));

      // Ack on the cycle the counter reaches TIMEOUT-1 wins
      drive(1'b1, 5'd2, 1'b0, 4'd0, 32'h0, 1'b0);
      expect_step(mk(32'h80000011, 4'd0, 1, 0, 0));
      for (int k = 1; k < 8; k++) begin
         step_idle(1'b0);
         expect_step(mk(32'h80000011, 4'd0, 1, 0, 0));
      end
      step_idle(1'b1);
      expect_step(mk(32'h00000022, 4'd1, 1, 0, 0));
      step_idle(1'b0);
      expect_step(mk(32'h00000022, 4'd1, 0, 1, 0));

      // Reset mid-sequence, overriding start and load
      drive(1'b1, 5'd3, 1'b0, 4'd0, 32'h0, 1'b0);
      expect_step(mk(32'h80000011, 4'd0, 1, 0, 0));
      step_idle(1'b1);
      expect_step(mk(32'h00000022, 4'd1, 1, 0, 0));
      i_reset = 1'b1;
      drive(1'b1, 5'd3, 1'b1, 4'd0, 32'hdead, 1'b0);
      expect_step(mk(32'h0, 4'd0, 0, 0, 0));
      i_reset = 1'b0;
      step_idle(1'b0);
      expect_step(mk(32'h0, 4'd0, 0, 0, 0));

      // Oversized len clamps to DEPTH; every cleared entry reads 0
      drive(1'b1, 5'd31, 1'b0, 4'd0, 32'h0, 1'b0);
      expect_step(mk(32'h80000000, 4'd0, 1, 0, 0));
      for (int k = 1; k < 16; k++) begin
         step_idle((k % 2) == 1);
         ph = (k % 2) == 0;
         expect_step(mk({ph, 31'h0}, 4'(k), 1, 0, 0));
      end
      step_idle(1'b0);
      expect_step(mk(32'h0, 4'd15, 0, 1, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sw_driver.md
SW_DRIVER -- requirements
Module: sw_driver

Interface
REQ-001 Parameter DEPTH, default 16: number of 32-bit stimulus words held in the table.
REQ-002 Parameter TIMEOUT, default 1024: maximum cycles spent waiting for one ack.
REQ-003 i_clk  in  1  clock; all logic is on the posedge.
REQ-004 i_reset  in  1  reset, synchronous, active-high.
REQ-005 i_load_en  in  1  table write strobe.
REQ-006 i_load_addr  in  $clog2(DEPTH)  table write index.
REQ-007 i_load_data  in  32  table write data.
REQ-008 i_start  in  1  begins a sequence.
REQ-009 i_len  in  $clog2(DEPTH)+1  number of words to present.
REQ-010 i_io_ledg  in  32  CPU output; bit 0 is the ack phase, other bits are ignored.
REQ-011 o_io_sw  out  32  drives the CPU switch input; bit 31 is the phase, bits 30:0 are data.
REQ-012 o_busy  out  1  sequence in progress.
REQ-013 o_done  out  1  sequence completed; sticky.
REQ-014 o_timeout  out  1  ack not received in time; sticky.
REQ-015 o_idx  out  $clog2(DEPTH)  index of the word currently presented.

Function
REQ-016 FSM states SHALL be IDLE, WAIT_ACK, DONE and TOUT.
REQ-017 i_load_en SHALL write table[i_load_addr] only in IDLE, DONE or TOUT, and SHALL be ignored in WAIT_ACK.
REQ-018 i_start SHALL be accepted in IDLE, DONE or TOUT, and SHALL be ignored in WAIT_ACK.
REQ-019 i_start SHALL have priority over i_load_en in the same cycle; that cycle's load is dropped.
REQ-020 Start with i_len=0 SHALL go directly to DONE; o_io_sw is unchanged.
REQ-021 i_len>DEPTH SHALL be clamped to DEPTH.
REQ-022 Start with i_len>=1 SHALL, at the next edge: enter WAIT_ACK, set o_idx=0, toggle phase, set o_io_sw={phase, table[0][30:0]}, clear o_done and o_timeout, and clear the timeout counter.
REQ-023 An ack SHALL be the cycle in which state is WAIT_ACK and i_io_ledg[0]==o_io_sw[31]; the ack is level-compared, not edge-detected.
REQ-024 An ack on a non-final word SHALL, at the next edge: increment o_idx, toggle phase, load the next word, and clear the timeout counter.
REQ-025 An ack on the final word (o_idx==len-1) SHALL enter DONE at the next edge; o_io_sw holds its last value.
REQ-026 Latency SHALL be exactly 1 cycle from ack to o_io_sw update.
REQ-027 The timeout counter SHALL increment each non-ack cycle in WAIT_ACK; on reaching TIMEOUT-1 without an ack it SHALL enter TOUT, with o_timeout=1.
REQ-028 An ack in the same cycle the counter reaches TIMEOUT-1 SHALL win; no timeout is raised.
REQ-029 o_busy SHALL be 1 exactly when state is WAIT_ACK.
REQ-030 o_done SHALL be 1 exactly in DONE.
REQ-031 o_timeout SHALL be 1 exactly in TOUT.
REQ-032 o_io_sw SHALL be registered, with no combinational path from any input.

Reset
REQ-033 i_reset SHALL take effect at any state, including mid-sequence, and SHALL result in: state=IDLE, o_io_sw=0 (phase 0), o_idx=0, o_busy=0, o_done=0, o_timeout=0, timeout counter=0.
REQ-034 i_reset SHALL clear every table entry to 0.
REQ-035 i_reset SHALL override i_start and i_load_en.

Structure
REQ-036 Package sw_driver_pkg SHALL hold the state enum typedef, DEPTH_DEF=16 and TIMEOUT_DEF=1024.
REQ-037 The table SHALL be sub-module sw_table: a DEPTH x 32 register file with synchronous reset, one write port and one asynchronous read port.
REQ-038 The FSM, phase, index and timeout counter SHALL be implemented in sw_driver.

Verification
REQ-039 Load table[0..2] = 0x11, 0x22, 0x33; start with len=3; ack by setting ledg[0]=1, then 0, then 1 -> o_io_sw sequence 0x80000011, 0x00000022, 0x80000033; o_done=1 one cycle after the third ack.
REQ-040 Start with len=2; hold ledg[0]=0 throughout, with TIMEOUT=8 -> o_timeout=1 after 8 cycles in WAIT_ACK; o_idx=0; o_busy=0.
REQ-041 Assert i_reset during word 1 of a len=3 sequence -> next edge: o_io_sw=0, all flags 0, state IDLE, all table entries read 0.
REQ-042 Start with len=0 -> o_done=1 next cycle; o_io_sw is unchanged.
REQ-043 Assert i_start and i_load_en (addr 0, data 0x55) in the same cycle, table[0]=0x11 -> the word presented is 0x80000011 and table[0] remains 0x11.
REQ-044 Pulse i_load_en and i_start while busy -> both are ignored; the sequence continues unchanged.
